alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Registered output stage directly downstream of the 32-bit ALU: captures each ALU result with its operation code and overflow bit, derives zero/negative flags, and hands it to the consumer (writeback/flag logic) through a 2-entry valid/ready skid buffer. It breaks every combinational path between the ALU and the consumer and sustains one result per cycle. It also keeps a sticky overflow flag and a saturating overflow counter for status reporting.

## Interface

- WIDTH, 32, data width of the ALU result
- CNT_WIDTH, 8, width of the overflow event counter
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  ALU result on in_result/in_overflow/in_operation is valid
- in_ready  output  1  stage can accept an entry this cycle
- in_result  input  WIDTH  ALU out bus
- in_overflow  input  1  ALU overflow output
- in_operation  input  3  ALU operation code for this result, passed through unmodified
- out_valid  output  1  head entry valid
- out_ready  input  1  consumer accepts head entry this cycle
- out_result  output  WIDTH  head entry result
- out_operation  output  3  head entry operation code
- out_zero  output  1  head result == 0
- out_negative  output  1  head result bit WIDTH-1
- out_overflow  output  1  head entry overflow bit
- sticky_overflow  output  1  set when an overflowing entry is delivered downstream
- clear_sticky  input  1  synchronous clear of sticky_overflow
- overflow_count  output  CNT_WIDTH  saturating count of delivered overflowing entries

## Operation

- Storage: 2 entries, each {result, operation, zero, negative, overflow}, plus occupancy count (0..2), read and write pointers (1 bit each, wrap 1->0).
- Flags zero/negative are computed from in_result when the entry is written, not at output.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != 2). Combinational from registered count only; it does not depend on out_ready.
- out_valid = (count != 0). out_* fields are driven from the entry at the read pointer. They are registered state: there is no combinational path from any in_* input to any out_* output.
- Count transitions:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged; both pointers advance.
- Full (count 2): in_ready=0, so in_valid is ignored and no data is lost or overwritten.
- Empty (count 0): out_valid=0; out_* data holds last-read-entry contents, but flag outputs (zero/negative/overflow) are forced to 0.
- Entries are delivered strictly in acceptance order.
- Sticky overflow: on pop of an entry with overflow=1, sticky_overflow <= 1. If clear_sticky=1 in a cycle with no such pop, sticky_overflow <= 0. If both occur in the same cycle, set wins and sticky_overflow stays 1.
- overflow_count increments by 1 on each pop of an entry with overflow=1 and saturates at 2^CNT_WIDTH-1 (no wrap). clear_sticky does not affect it; only reset clears it.
- Reset: asynchronous and active-high. It immediately sets count=0, pointers=0, sticky_overflow=0, overflow_count=0, and all entry storage to 0.
  - Resulting outputs: out_valid=0, out_result=0, out_operation=0, out_zero=0, out_negative=0, out_overflow=0, in_ready=1.
  - Reset mid-transfer discards all held entries.
  - The first push is accepted on the first rising edge after reset deasserts.

## Timing

- Latency: entry accepted at edge N is visible on out_* with out_valid=1 after edge N, i.e. in cycle N+1, when the buffer was empty.
- Throughput: 1 entry/cycle when out_ready is held high. Count oscillates 0->1 and stays 1 under continuous push+pop.
- Back-pressure: out_ready low for k cycles with continuous in_valid:
  - 2 entries accepted.
  - in_ready drops the cycle after the second accept.
  - in_ready returns to 1 the cycle after the first pop.
- sticky_overflow and overflow_count update at the same edge as the pop that causes them.
- The upstream ALU is purely combinational with gate delays up to several hundred time units. The clock period must exceed ALU settling time, and this block samples in_* only at the rising edge.

## Test plan

- Reset: assert reset asynchronously mid-cycle with 2 entries held. Required: out_valid=0, all out_* = 0, in_ready=1, sticky_overflow=0, overflow_count=0 before the next edge.
- Streaming: push results 0x00000000, 0x80000000, 0x00000005 back-to-back with out_ready=1.
  - Delivered in order, one cycle after each accept.
  - Flags per entry (zero/negative): 1/0, 0/1, 0/0.
- Back-pressure: out_ready=0, in_valid=1 with values 0x11, 0x22, 0x33.
  - Only 0x11 and 0x22 are accepted, and in_ready=0.
  - Raise out_ready: 0x11, 0x22, 0x33 are delivered in order, and no value is duplicated.
- Simultaneous push/pop at count 1: count stays 1, the new entry follows the popped one, and in_ready stays 1.
- Sticky and clear:
  - Deliver an entry with in_overflow=1 (result 0x80000000 from 0x7FFFFFFF+1), asserting clear_sticky in the same cycle as the pop. Required: sticky_overflow=1, overflow_count=1.
  - Next cycle, with clear_sticky=1 and no pop: sticky_overflow=0, overflow_count stays 1.
- Saturation: with CNT_WIDTH=2, deliver 5 overflowing entries. overflow_count reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/alu_result_stage.sv
// Registered result stage behind the ALU: a 2-entry skid buffer carrying result,
// opcode and derived flags, plus sticky/saturating overflow status.
module alu_result_stage #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_result,
    input  logic                 in_overflow,
    input  logic [2:0]           in_operation,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [2:0]           out_operation,
    output logic                 out_zero,
    output logic                 out_negative,
    output logic                 out_overflow,
    output logic                 sticky_overflow,
    input  logic                 clear_sticky,
    output logic [CNT_WIDTH-1:0] overflow_count
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned OCC_W = 2;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [2:0]       operation;
        logic             zero;
        logic             negative;
        logic             overflow;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [OCC_W-1:0]   count;
    logic               wr_ptr;
    logic               rd_ptr;
    logic               push;
    logic               pop;
    logic               pop_ovf;
    logic               not_empty;
    entry_t             head;
    entry_t             shown;
    entry_t             wr_entry;

    assign not_empty = (count != OCC_W'(0));
    assign in_ready  = (count != OCC_W'(DEPTH));
    assign out_valid = not_empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head      = mem[rd_ptr];
    assign pop_ovf   = pop & head.overflow;

    // When empty, present the last entry read (one slot behind the read pointer).
    assign shown         = not_empty ? head : mem[~rd_ptr];
    assign out_result    = shown.result;
    assign out_operation = shown.operation;
    assign out_zero      = not_empty & head.zero;
    assign out_negative  = not_empty & head.negative;
    assign out_overflow  = not_empty & head.overflow;

    always_comb begin
        wr_entry           = '0;
        wr_entry.result    = in_result;
        wr_entry.operation = in_operation;
        wr_entry.zero      = (in_result == '0);
        wr_entry.negative  = in_result[WIDTH-1];
        wr_entry.overflow  = in_overflow;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
            count           <= '0;
            wr_ptr          <= 1'b0;
            rd_ptr          <= 1'b0;
            sticky_overflow <= 1'b0;
            overflow_count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + OCC_W'(1);
                2'b01:   count <= count - OCC_W'(1);
                default: count <= count;
            endcase
            // Set beats clear when both happen in the same cycle.
            if (pop_ovf)           sticky_overflow <= 1'b1;
            else if (clear_sticky) sticky_overflow <= 1'b0;
            if (pop_ovf && overflow_count != CNT_MAX)
                overflow_count <= overflow_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized and directed bench for alu_result_stage against a queue-based model.
module tb_alu_result_stage;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned CNT_WIDTH = 2;
    localparam int unsigned CNT_MAX   = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_result;
    logic                 in_overflow;
    logic [2:0]           in_operation;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_result;
    logic [2:0]           out_operation;
    logic                 out_zero;
    logic                 out_negative;
    logic                 out_overflow;
    logic                 sticky_overflow;
    logic                 clear_sticky;
    logic [CNT_WIDTH-1:0] overflow_count;

    alu_result_stage #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_overflow(in_overflow), .in_operation(in_operation),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_operation(out_operation), .out_zero(out_zero),
        .out_negative(out_negative), .out_overflow(out_overflow),
        .sticky_overflow(sticky_overflow), .clear_sticky(clear_sticky),
        .overflow_count(overflow_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] r;
        logic [2:0]       op;
        logic             ovf;
    } ent_t;

    ent_t             q[$];
    logic [WIDTH-1:0] delivered[$];
    int unsigned      m_sticky;
    int unsigned      m_cnt;
    bit               last_push;
    int               tests = 0;
    int               errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        delivered.delete();
        m_sticky = 0;
        m_cnt    = 0;
    endtask

    // Compare all outputs with the model; outputs depend only on held state.
    task automatic check_outputs();
        check("in_ready", 64'(in_ready), 64'(q.size() < 2));
        check("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() != 0) begin
            check("out_result", 64'(out_result), 64'(q[0].r));
            check("out_operation", 64'(out_operation), 64'(q[0].op));
            check("out_zero", 64'(out_zero), 64'(q[0].r == 0));
            check("out_negative", 64'(out_negative), 64'(q[0].r[WIDTH-1]));
            check("out_overflow", 64'(out_overflow), 64'(q[0].ovf));
        end else begin
            check("empty_flags", 64'({out_zero, out_negative, out_overflow}), 64'(0));
        end
        check("sticky", 64'(sticky_overflow), 64'(m_sticky));
        check("ovf_count", 64'(overflow_count), 64'(m_cnt));
    endtask

    task automatic model_update(input logic v, input logic [WIDTH-1:0] r, input logic o,
                                input logic [2:0] op, input logic rdy, input logic clr);
        bit   do_push;
        bit   do_pop;
        ent_t e;
        do_push = v && (q.size() < 2);
        do_pop  = rdy && (q.size() != 0);
        if (do_pop) begin
            e = q.pop_front();
            delivered.push_back(e.r);
            if (e.ovf) begin
                m_sticky = 1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else if (clr) begin
                m_sticky = 0;
            end
        end else if (clr) begin
            m_sticky = 0;
        end
        if (do_push) begin
            e.r = r; e.op = op; e.ovf = o;
            q.push_back(e);
        end
        last_push = do_push;
    endtask

    task automatic step(input logic v, input logic [WIDTH-1:0] r, input logic o,
                        input logic [2:0] op, input logic rdy, input logic clr);
        @(negedge clk);
        check_outputs();
        in_valid = v; in_result = r; in_overflow = o; in_operation = op;
        out_ready = rdy; clear_sticky = clr;
        @(posedge clk);
        model_update(v, r, o, op, rdy, clr);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; clear_sticky = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_vals [3];
        int               n;
        reset = 1'b1; in_valid = 1'b0; in_result = '0; in_overflow = 1'b0;
        in_operation = '0; out_ready = 1'b0; clear_sticky = 1'b0;
        model_reset();
        #12;
        check_outputs();
        reset = 1'b0;

        // Streaming with flags.
        step(1, 32'h0000_0000, 0, 3'd1, 1, 0);
        check("lat_valid", 64'(out_valid), 64'(1));
        check("lat_zero", 64'(out_zero), 64'(1));
        step(1, 32'h8000_0000, 0, 3'd2, 1, 0);
        check("stream_neg", 64'(out_negative), 64'(1));
        step(1, 32'h0000_0005, 0, 3'd3, 1, 0);
        check("stream_plain", 64'({out_zero, out_negative}), 64'(0));
        step(0, '0, 0, 3'd0, 1, 0);
        step(0, '0, 0, 3'd0, 1, 0);
        exp_vals[0] = 32'h0; exp_vals[1] = 32'h8000_0000; exp_vals[2] = 32'h5;
        check("stream_count", 64'(delivered.size()), 64'(3));
        for (int i = 0; i < 3 && i < delivered.size(); i++)
            check("stream_order", 64'(delivered[i]), 64'(exp_vals[i]));

        // Back-pressure.
        delivered.delete();
        step(1, 32'h11, 0, 3'd4, 0, 0);
        step(1, 32'h22, 0, 3'd5, 0, 0);
        check("bp_full_ready", 64'(in_ready), 64'(0));
        step(1, 32'h33, 0, 3'd6, 0, 0);
        check("bp_not_taken", 64'(last_push), 64'(0));
        n = 0;
        do begin
            step(1, 32'h33, 0, 3'd6, 1, 0);
            n++;
        end while (!last_push && n < 8);
        check("bp_accept_33", 64'(last_push), 64'(1));
        n = 0;
        while (q.size() != 0 && n < 8) begin
            step(0, '0, 0, 3'd0, 1, 0);
            n++;
        end
        exp_vals[0] = 32'h11; exp_vals[1] = 32'h22; exp_vals[2] = 32'h33;
        check("bp_count", 64'(delivered.size()), 64'(3));
        for (int i = 0; i < 3 && i < delivered.size(); i++)
            check("bp_order", 64'(delivered[i]), 64'(exp_vals[i]));

        // Simultaneous push and pop at one entry.
        step(1, 32'hA, 0, 3'd1, 0, 0);
        step(1, 32'hB, 0, 3'd2, 1, 0);
        check("pp_ready", 64'(in_ready), 64'(1));
        check("pp_valid", 64'(out_valid), 64'(1));
        check("pp_head", 64'(out_result), 64'(32'hB));

        // Asynchronous reset mid-cycle with two entries held.
        step(1, 32'hC, 1, 3'd3, 0, 0);
        check("rst_pre_full", 64'(in_ready), 64'(0));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(1));
        check("rst_data", 64'({out_result, out_operation}), 64'(0));
        check("rst_flags", 64'({out_zero, out_negative, out_overflow}), 64'(0));
        check("rst_status", 64'({sticky_overflow, overflow_count}), 64'(0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Sticky set wins over clear; clear alone then drops it.
        step(1, 32'h8000_0000, 1, 3'd0, 0, 0);
        step(0, '0, 0, 3'd0, 1, 1);
        check("sticky_set", 64'(sticky_overflow), 64'(1));
        check("sticky_cnt1", 64'(overflow_count), 64'(1));
        step(0, '0, 0, 3'd0, 0, 1);
        check("sticky_clr", 64'(sticky_overflow), 64'(0));
        check("sticky_cnt_hold", 64'(overflow_count), 64'(1));

        // Saturation of the 2-bit counter.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h8000_0000, 1, 3'd7, 0, 0);
            step(0, '0, 0, 3'd0, 1, 0);
            check("sat_count", 64'(overflow_count), 64'((i + 1 < 3) ? i + 1 : 3));
        end

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [WIDTH-1:0] r;
            case ($urandom_range(0, 3))
                0:       r = '0;
                1:       r = {1'b1, 31'($urandom)};
                default: r = WIDTH'($urandom);
            endcase
            step(1'($urandom_range(0, 99) < 70), r, 1'($urandom_range(0, 9) < 3),
                 3'($urandom), 1'($urandom_range(0, 99) < 60),
                 1'($urandom_range(0, 9) < 2));
        end
        idle();
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
